decode_legality_pipe: RTL and testbench

Registered, multi-lane successor to the combinational illegal-instruction check. Each cycle it accepts up to NUM_LANES fetched instructions and classifies each against the configured ISA and the current privilege level. Results come out one cycle later, with in-order squash of younger lanes and the trap value for the faulting lane. After an illegal instruction is handed off, the block holds off further input until the pipeline issues a flush, and it keeps a saturating count of illegal instructions.

---
 rtl/decode_legality_if.sv | 22 ++
 rtl/decode_legality_pipe.sv | 179 +++++++++++++++++
 tb/tb_decode_legality_pipe.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_legality_if.sv
// rtl/decode_legality_if.sv - lane group handshake between fetch and decode legality stage
interface decode_legality_if #(
  parameter int NUM_LANES = 2
);
  logic [NUM_LANES-1:0]       in_valid;
  logic [NUM_LANES-1:0][31:0] in_instruction;
  logic                       in_ready;
  logic [NUM_LANES-1:0]       out_valid;
  logic [NUM_LANES-1:0]       out_illegal;
  logic [NUM_LANES-1:0][31:0] out_tval;
  logic                       out_ready;

  modport master (
    output in_valid, in_instruction, out_ready,
    input  in_ready, out_valid, out_illegal, out_tval
  );

  modport slave (
    input  in_valid, in_instruction, out_ready,
    output in_ready, out_valid, out_illegal, out_tval
  );
endinterface

// File: rtl/decode_legality_pipe.sv
// rtl/decode_legality_pipe.sv - registered multi-lane illegal-instruction classifier with trap hold
package decode_legality_pkg;
  typedef struct packed {
    logic INCLUDE_CSRS;
    logic INCLUDE_MUL;
    logic INCLUDE_DIV;
    logic INCLUDE_AMO;
    logic INCLUDE_IFENCE;
    logic INCLUDE_M_MODE;
    logic INCLUDE_S_MODE;
  } cpu_config_t;

  localparam cpu_config_t EXAMPLE_CONFIG = '{
    INCLUDE_CSRS: 1'b1, INCLUDE_MUL: 1'b1, INCLUDE_DIV: 1'b1, INCLUDE_AMO: 1'b1,
    INCLUDE_IFENCE: 1'b1, INCLUDE_M_MODE: 1'b1, INCLUDE_S_MODE: 1'b1
  };
endpackage

module decode_legality_pipe
  import decode_legality_pkg::*;
#(
  parameter cpu_config_t CONFIG    = EXAMPLE_CONFIG,
  parameter int          NUM_LANES = 2,
  parameter int          COUNTER_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decode_legality_if.slave     lanes,
  input  logic [1:0]           priv_level,
  input  logic                 mstatus_tw,
  input  logic                 flush,
  output logic [COUNTER_W-1:0] illegal_count
);

  typedef enum logic {ST_RUN, ST_TRAP_HOLD} state_t;

  state_t                     state, state_next;
  logic [NUM_LANES-1:0]       valid_q, illegal_q, valid_d, illegal_d;
  logic [NUM_LANES-1:0][31:0] tval_q, tval_d;
  logic                       ready, handoff, fault_seen;
  logic [COUNTER_W-1:0]       count_q;

  // Counters/FP CSRs are always present; machine and supervisor ranges follow the mode flags.
  function automatic logic csr_known(input logic [11:0] csr);
    logic hit;
    hit = (csr >= 12'h001) && (csr <= 12'h003);
    if (csr[11:8] == 4'hC && (csr[7:0] < 8'h20 || (csr[7:0] >= 8'h80 && csr[7:0] < 8'hA0)))
      hit = 1'b1;
    if (csr[9:8] == 2'b11 && CONFIG.INCLUDE_M_MODE) hit = 1'b1;
    if (csr[9:8] == 2'b01 && CONFIG.INCLUDE_S_MODE) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic lane_legal(input logic [31:0] insn, input logic [1:0] priv,
                                      input logic tw);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] csr;
    logic        csr_write;
    logic        ok;
    f3        = insn[14:12];
    f7        = insn[31:25];
    csr       = insn[31:20];
    csr_write = (f3[1:0] == 2'b01) || (insn[19:15] != 5'd0);
    ok        = 1'b0;
    if (insn[1:0] == 2'b11) begin
      case (insn[6:2])
        5'b01101, 5'b00101, 5'b11011: ok = 1'b1;
        5'b11001: ok = (f3 == 3'b000);
        5'b11000: ok = (f3 != 3'b010) && (f3 != 3'b011);
        5'b00000: ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        5'b01000: ok = f3 inside {3'b000, 3'b001, 3'b010};
        5'b00100: begin
          case (f3)
            3'b001:  ok = (f7 == 7'b0000000);
            3'b101:  ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            default: ok = 1'b1;
          endcase
        end
        5'b01100: begin
          if (f7 == 7'b0000000)      ok = 1'b1;
          else if (f7 == 7'b0100000) ok = (f3 == 3'b000) || (f3 == 3'b101);
          else if (f7 == 7'b0000001) ok = f3[2] ? CONFIG.INCLUDE_DIV : CONFIG.INCLUDE_MUL;
        end
        5'b00011: ok = (f3 == 3'b000) || (f3 == 3'b001 && CONFIG.INCLUDE_IFENCE);
        5'b01011: ok = CONFIG.INCLUDE_AMO && (f3 == 3'b010)
                       && (insn[31:27] inside {5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                               5'b01000, 5'b01100, 5'b10000, 5'b10100, 5'b11000,
                                               5'b11100})
                       && (insn[31:27] != 5'b00010 || insn[24:20] == 5'd0);
        5'b11100: begin
          if (f3 == 3'b000) begin
            case (insn)
              32'h00000073, 32'h00100073: ok = CONFIG.INCLUDE_M_MODE;
              32'h30200073: ok = CONFIG.INCLUDE_M_MODE && (priv == 2'b11);
              32'h10200073: ok = CONFIG.INCLUDE_S_MODE && (priv != 2'b00);
              32'h10500073: ok = CONFIG.INCLUDE_S_MODE && !((priv != 2'b11) && tw);
              // Remaining funct3=000 space: only SFENCE.VMA (rd = 0) is defined.
              default: ok = CONFIG.INCLUDE_S_MODE && (f7 == 7'b0001001)
                            && (insn[11:7] == 5'd0) && (priv != 2'b00);
            endcase
          end else if (f3 != 3'b100) begin
            ok = CONFIG.INCLUDE_CSRS && csr_known(csr) && (csr[9:8] <= priv)
                 && !((csr[11:10] == 2'b11) && csr_write);
          end
        end
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Oldest illegal lane wins; everything younger is squashed.
  always_comb begin : classify
    valid_d    = '0;
    illegal_d  = '0;
    tval_d     = '0;
    fault_seen = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lanes.in_valid[i] && !fault_seen) begin
        valid_d[i] = 1'b1;
        if (!lane_legal(lanes.in_instruction[i], priv_level, mstatus_tw)) begin
          illegal_d[i] = 1'b1;
          tval_d[i]    = lanes.in_instruction[i];
          fault_seen   = 1'b1;
        end
      end
    end
  end

  always_comb begin : fsm
    state_next = state;
    ready      = 1'b0;
    handoff    = (|valid_q) && lanes.out_ready;
    case (state)
      ST_RUN: begin
        ready = (~|valid_q || lanes.out_ready) && !((|valid_q) && (|illegal_q)) && !flush;
        if (handoff && (|illegal_q)) state_next = ST_TRAP_HOLD;
      end
      ST_TRAP_HOLD: ready = 1'b0;
      default:      state_next = ST_RUN;
    endcase
    if (flush) state_next = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      valid_q   <= '0;
      illegal_q <= '0;
      tval_q    <= '0;
      count_q   <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        valid_q   <= '0;
        illegal_q <= '0;
        tval_q    <= '0;
      end else if (ready) begin
        valid_q   <= valid_d;
        illegal_q <= illegal_d;
        tval_q    <= tval_d;
      end else if (handoff) begin
        valid_q   <= '0;
        illegal_q <= '0;
        tval_q    <= '0;
      end
      if (!flush && handoff && (|illegal_q) && (count_q != {COUNTER_W{1'b1}}))
        count_q <= count_q + COUNTER_W'(1);
    end
  end

  assign lanes.in_ready    = ready;
  assign lanes.out_valid   = valid_q;
  assign lanes.out_illegal = illegal_q;
  assign lanes.out_tval    = tval_q;
  assign illegal_count     = count_q;

endmodule

// File: tb/tb_decode_legality_pipe.sv
// tb/tb_decode_legality_pipe.sv - directed and randomized bench for decode_legality_pipe
module tb_decode_legality_pipe;
  localparam int NL = 2;
  localparam int CW = 4;
  localparam bit [31:0] ADDI = 32'h00500093;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    priv_level;
  logic          mstatus_tw;
  logic          flush;
  logic [CW-1:0] illegal_count;

  decode_legality_if #(.NUM_LANES(NL)) bus ();

  decode_legality_pipe #(.NUM_LANES(NL), .COUNTER_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .lanes(bus), .priv_level(priv_level),
    .mstatus_tw(mstatus_tw), .flush(flush), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit [1:0]  m_valid, m_illegal;
  bit [31:0] m_tval [NL];
  bit        m_trap;
  int        m_cnt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference legality for the instruction classes the bench generates.
  function automatic bit ref_legal(bit [31:0] x, bit [1:0] pv, bit tw);
    bit [11:0] csr = x[31:20];
    bit [2:0]  f3 = x[14:12];
    bit [6:0]  f7 = x[31:25];
    bit        wr;
    if (x[1:0] != 2'b11) return 0;
    case (x[6:0])
      7'h13: begin
        if (f3 == 1) return f7 == 0;
        if (f3 == 5) return f7 == 0 || f7 == 7'h20;
        return 1;
      end
      7'h33: begin
        if (f7 == 7'h20) return f3 == 0 || f3 == 5;
        return f7 == 0 || f7 == 1;
      end
      7'h0F: return f3 <= 1;
      7'h73: begin
        if (x == 32'h30200073) return pv == 3;
        if (x == 32'h10200073) return pv != 0;
        if (x == 32'h10500073) return pv == 3 || !tw;
        if (x == 32'h00000073 || x == 32'h00100073) return 1;
        if (f3 == 0 || f3 == 4) return 0;
        if (!(csr inside {12'hC00, 12'hC01, 12'hC80, 12'h001, 12'h003, 12'h300,
                          12'h305, 12'h341, 12'hF11, 12'h7C0, 12'h100, 12'h180})) return 0;
        if (csr[9:8] > pv) return 0;
        wr = (f3[1:0] == 2'b01) || (x[19:15] != 0);
        return !(csr[11:10] == 2'b11 && wr);
      end
      default: return 0;
    endcase
  endfunction

  function automatic bit [31:0] gen_insn();
    bit [11:0] csrs [14] = '{12'hC00, 12'hC01, 12'hC80, 12'h001, 12'h003, 12'h300, 12'h305,
                             12'h341, 12'hF11, 12'h7C0, 12'h100, 12'h180, 12'h200, 12'h041};
    bit [31:0] r = $urandom;
    case ($urandom_range(0, 9))
      0: return {r[31:2], 2'($urandom_range(0, 2))};
      1: return {r[31:15], 3'b000, r[11:7], 7'h13};
      2: return {1'b0, r[30], 5'b0, r[24:15], 3'b000, r[11:7], 7'h33};
      3: return {7'h01, r[24:7], 7'h33};
      4: return 32'h30200073;
      5: return 32'h10200073;
      6: return 32'h10500073;
      7, 8: return {csrs[$urandom_range(0, 13)], (r[0] ? r[19:15] : 5'd0),
                    3'($urandom_range(1, 7)), r[11:7], 7'h73};
      default: return r[0] ? 32'h0000000F : 32'h00000073;
    endcase
  endfunction

  task automatic m_reset();
    m_valid = 0; m_illegal = 0; m_tval = '{0, 0}; m_trap = 0; m_cnt = 0;
  endtask

  task automatic drive(bit [1:0] v, bit [31:0] i0, bit [31:0] i1, bit [1:0] pv, bit tw,
                       bit ordy, bit fl);
    bus.in_valid = v; bus.in_instruction[0] = i0; bus.in_instruction[1] = i1;
    priv_level = pv; mstatus_tw = tw; bus.out_ready = ordy; flush = fl;
  endtask

  // Check everything against the model, then advance the model across the next edge.
  task automatic cycle();
    bit rdy, ho;
    int k;
    @(negedge clk);
    rdy = !flush && !m_trap && (m_valid == 0 || bus.out_ready) && !(m_valid != 0 && m_illegal != 0);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_illegal", 32'(bus.out_illegal), 32'(m_illegal));
    chk("out_tval0", bus.out_tval[0], m_tval[0]);
    chk("out_tval1", bus.out_tval[1], m_tval[1]);
    chk("illegal_count", 32'(illegal_count), 32'(m_cnt));
    ho = (m_valid != 0) && bus.out_ready && !flush;
    if (flush) begin
      m_valid = 0; m_illegal = 0; m_tval = '{0, 0}; m_trap = 0;
    end else begin
      if (ho && m_illegal != 0) begin
        m_trap = 1;
        if (m_cnt < 2**CW - 1) m_cnt++;
      end
      if (rdy) begin
        k = NL;
        for (int i = NL - 1; i >= 0; i--)
          if (bus.in_valid[i] && !ref_legal(bus.in_instruction[i], priv_level, mstatus_tw)) k = i;
        m_valid = bus.in_valid; m_illegal = 0; m_tval = '{0, 0};
        if (k < NL) begin
          m_valid   = m_valid & 2'((1 << (k + 1)) - 1);
          m_illegal = 2'(1 << k);
          m_tval[k] = bus.in_instruction[k];
        end
      end else if (ho) begin
        m_valid = 0; m_illegal = 0; m_tval = '{0, 0};
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct { bit [31:0] insn; bit [1:0] pv; bit tw; bit ill; } priv_case_t;
  priv_case_t pcases [7] = '{
    '{32'h30200073, 2'd1, 1'b0, 1'b1}, '{32'h30200073, 2'd3, 1'b0, 1'b0},
    '{32'hC0001073, 2'd3, 1'b0, 1'b1}, '{32'hC00020F3, 2'd3, 1'b0, 1'b0},
    '{32'h10500073, 2'd0, 1'b1, 1'b1}, '{32'h10500073, 2'd1, 1'b0, 1'b0},
    '{32'h10200073, 2'd0, 1'b0, 1'b1}
  };

  initial begin
    int exp_cnt;
    bit [1:0] nvl;
    drive(0, 0, 0, 3, 0, 1, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("reset_in_ready", 32'(bus.in_ready), 1);
    cycle();

    drive(2'b11, ADDI, 32'hFFFFFFFF, 3, 0, 1, 0); cycle();
    chk("mix_valid", 32'(bus.out_valid), 3);
    chk("mix_illegal", 32'(bus.out_illegal), 2);
    chk("mix_tval1", bus.out_tval[1], 32'hFFFFFFFF);
    chk("mix_tval0", bus.out_tval[0], 0);
    drive(2'b11, ADDI, ADDI, 3, 0, 1, 0); cycle();
    chk("mix_count", 32'(illegal_count), 1);
    chk("mix_hold_ready", 32'(bus.in_ready), 0);
    cycle();
    drive(2'b11, ADDI, ADDI, 3, 0, 1, 1); cycle();
    drive(0, 0, 0, 3, 0, 1, 0);
    #1 chk("mix_flush_ready", 32'(bus.in_ready), 1);

    drive(2'b11, 32'h00000000, ADDI, 3, 0, 1, 0); cycle();
    chk("squash_valid", 32'(bus.out_valid), 1);
    chk("squash_illegal", 32'(bus.out_illegal), 1);
    chk("squash_tval0", bus.out_tval[0], 0);
    drive(0, 0, 0, 3, 0, 1, 0); cycle();
    drive(0, 0, 0, 3, 0, 1, 1); cycle();

    foreach (pcases[i]) begin
      drive(2'b01, pcases[i].insn, 0, pcases[i].pv, pcases[i].tw, 1, 0); cycle();
      chk($sformatf("priv_case%0d", i), 32'(bus.out_illegal[0]), 32'(pcases[i].ill));
      drive(0, 0, 0, 3, 0, 1, 0); cycle();
      drive(0, 0, 0, 3, 0, 1, 1); cycle();
    end

    drive(2'b11, ADDI, ADDI, 3, 0, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 32'h00A00113, 32'h00A00113, 3, 0, 0, 0); cycle();
      chk("bp_valid", 32'(bus.out_valid), 3);
      chk("bp_ready", 32'(bus.in_ready), 0);
    end
    drive(2'b01, 32'h00A00113, 0, 3, 0, 1, 0); cycle();
    chk("bp_next_valid", 32'(bus.out_valid), 1);

    drive(2'b01, 32'hFFFFFFFF, 0, 3, 0, 1, 0); cycle();
    exp_cnt = m_cnt;
    drive(0, 0, 0, 3, 0, 1, 1); cycle();
    chk("collide_count", 32'(illegal_count), 32'(exp_cnt));
    chk("collide_valid", 32'(bus.out_valid), 0);

    for (int i = 0; i < 20; i++) begin
      drive(2'b01, 32'hFFFFFFFF, 0, 3, 0, 1, 0); cycle();
      drive(0, 0, 0, 3, 0, 1, 0); cycle();
      drive(0, 0, 0, 3, 0, 1, 1); cycle();
    end
    chk("sat_count", 32'(illegal_count), 15);

    drive(2'b01, 32'h00000000, 0, 3, 0, 0, 0); cycle();
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_illegal", 32'(bus.out_illegal), 0);
    chk("arst_tval0", bus.out_tval[0], 0);
    chk("arst_count", 32'(illegal_count), 0);
    drive(0, 0, 0, 3, 0, 1, 0);
    @(posedge clk); #1 rst_n = 1'b1; m_reset();
    #1 chk("arst_release_ready", 32'(bus.in_ready), 1);
    drive(2'b01, 32'hFFFFFFFF, 0, 3, 0, 1, 0); cycle();
    drive(0, 0, 0, 3, 0, 1, 0); cycle();
    chk("trap_ready", 32'(bus.in_ready), 0);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; m_reset();
    #1 chk("trap_reset_ready", 32'(bus.in_ready), 1);
    cycle();

    for (int n = 0; n < 400; n++) begin
      nvl = 2'($urandom_range(0, 2));
      bus.in_valid = (nvl == 0) ? 2'b00 : (nvl == 1) ? 2'b01 : 2'b11;
      bus.in_instruction[0] = gen_insn();
      bus.in_instruction[1] = gen_insn();
      priv_level = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
      mstatus_tw = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush = m_trap ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
